bus_arbiter_rr: RTL

//  N-way round-robin arbiter sharing the single memory_controller port among per-hart bus masters.

---
 rtl/arvi_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/bus_arbiter_rr.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arvi_arb_pkg.sv
// rtl/arvi_arb_pkg.sv - shared types, limits and pointer helper for the round-robin bus arbiter
package arvi_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int ARB_MAX_MASTERS = 8;

  // Round-robin pointer increment, wrapping n-1 back to 0
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first requester at or after ptr, wrapping
module rr_pick #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;

  // Rotate a doubled request vector so ptr lands on bit 0, take the lowest set bit,
  // then map the offset back to an absolute master index modulo N
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    idx   = sum[ID_W-1:0];
    valid = |req;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-way round-robin arbiter onto one memory_controller port (optional ARVI_ARB_TIMEOUT_EN watchdog)
module bus_arbiter_rr
  import arvi_arb_pkg::*;
#(
  parameter int  N_MASTERS = 2,
  parameter int  TIMEOUT   = 255,
  localparam int ID_W      = $clog2(N_MASTERS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_MASTERS-1:0]        i_bus_en,
  input  logic [N_MASTERS-1:0]        i_wr_en,
  input  logic [N_MASTERS-1:0][31:0]  i_wr_data,
  input  logic [N_MASTERS-1:0][31:0]  i_addr,
  input  logic [N_MASTERS-1:0][3:0]   i_byte_en,
  input  logic [N_MASTERS-1:0]        i_atomic,
  input  logic [N_MASTERS-1:0][6:0]   i_operation,
  output logic [N_MASTERS-1:0]        o_ack,
  output logic [31:0]                 o_rd_data,
`ifdef ARVI_ARB_TIMEOUT_EN
  output logic                        o_err,
`endif
  output logic                        o_bus_en,
  output logic                        o_wr_en,
  output logic [31:0]                 o_wr_data,
  output logic [31:0]                 o_addr,
  output logic [3:0]                  o_byte_en,
  output logic                        o_atomic,
  output logic [6:0]                  o_operation,
  output logic [ID_W-1:0]             o_id,
  input  logic                        i_ack,
  input  logic [31:0]                 i_rd_data
);

  if (N_MASTERS < 2 || N_MASTERS > ARB_MAX_MASTERS || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("bus_arbiter_rr: illegal N_MASTERS or TIMEOUT");
  end

  arb_state_t      state, state_d;
  logic [ID_W-1:0] grant, grant_d;
  logic [ID_W-1:0] rr_ptr, rr_ptr_d;
  logic [ID_W-1:0] pick_idx;
  logic            pick_valid;
  logic            timeout_hit;
  logic            abort;

  rr_pick #(
    .N    (N_MASTERS),
    .ID_W (ID_W)
  ) u_pick (
    .req   (i_bus_en),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARVI_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Watchdog: zero while idle, counts each BUSY cycle that passes without i_ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      to_cnt <= '0;
    end else if (!i_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // The current cycle is the TIMEOUT-th silent BUSY cycle
  assign timeout_hit = (state == ARB_BUSY) && (to_cnt == 8'(TIMEOUT - 1));
  assign o_err       = abort;
`else
  assign timeout_hit = 1'b0;
`endif

  // State, grant and round-robin pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      rr_ptr <= rr_ptr_d;
    end
  end

  // Next-state logic and output mux; a real i_ack always takes precedence over a watchdog abort
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    rr_ptr_d    = rr_ptr;
    abort       = 1'b0;
    o_ack       = '0;
    o_rd_data   = i_rd_data;
    o_bus_en    = 1'b0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    o_addr      = '0;
    o_byte_en   = '0;
    o_atomic    = 1'b0;
    o_operation = '0;
    o_id        = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        o_bus_en    = 1'b1;
        o_wr_en     = i_wr_en[grant];
        o_wr_data   = i_wr_data[grant];
        o_addr      = i_addr[grant];
        o_byte_en   = i_byte_en[grant];
        o_atomic    = i_atomic[grant];
        o_operation = i_operation[grant];
        o_id        = grant;
        if (i_ack || timeout_hit) begin
          o_ack[grant] = 1'b1;
          state_d      = ARB_IDLE;
          rr_ptr_d     = ID_W'(rr_next(32'(grant), N_MASTERS));
          if (!i_ack) begin
            abort     = 1'b1;
            o_rd_data = 32'h0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
